// File: rtl/fetch_prefetch_unit_if.sv
// Bundle of imem, redirect and decode-side signals of the fetch/prefetch unit.
// master = the fetch unit itself, slave = the surrounding pipeline/memory.
interface fetch_prefetch_unit_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                  enable_fetch;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  imem_rd;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_rdata;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] npc;
   logic                  instr_valid;
   logic                  instr_ready;
   logic [DATA_WIDTH-1:0] instr;
   logic [ADDR_WIDTH-1:0] instr_pc;
   logic [ADDR_WIDTH-1:0] instr_npc;
   logic [CW-1:0]         fifo_count;

   modport master (
      input  enable_fetch, redirect_valid, redirect_pc, imem_rdata, instr_ready,
      output imem_rd, imem_addr, pc, npc, instr_valid, instr, instr_pc, instr_npc, fifo_count
   );

   modport slave (
      output enable_fetch, redirect_valid, redirect_pc, imem_rdata, instr_ready,
      input  imem_rd, imem_addr, pc, npc, instr_valid, instr, instr_pc, instr_npc, fifo_count
   );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage with a DEPTH-entry prefetch FIFO: owns pc/npc, issues imem reads one
// at a time under a credit check, and hands {instr, pc} to decode via valid/ready.
module fetch_prefetch_unit #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 16,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h3000
) (
   input logic                   clock,
   input logic                   reset,
   fetch_prefetch_unit_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [ADDR_WIDTH-1:0] pc;
   } entry_t;

   entry_t                mem [DEPTH];
   entry_t                head;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic [ADDR_WIDTH-1:0] fetch_pc, inflight_pc;
   logic                  inflight;
   logic [CW:0]           used;
   logic                  issue, push, pop, redirect;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Credit counts the outstanding read too, so a response always finds a free slot.
   assign redirect = bus.redirect_valid;
   assign used     = {1'b0, count} + (CW+1)'(inflight);
   assign issue    = reset & bus.enable_fetch & ~redirect & (used < (CW+1)'(DEPTH));
   assign push     = inflight & ~redirect;
   assign pop      = (count != '0) & bus.instr_ready & ~redirect;
   assign head     = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
      end else if (redirect) begin
         fetch_pc <= bus.redirect_pc;
         inflight <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            fetch_pc    <= fetch_pc + ADDR_WIDTH'(1);
            inflight_pc <= fetch_pc;
         end
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset: count gates visibility of every slot.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= '{data: bus.imem_rdata, pc: inflight_pc};
   end

   assign bus.imem_rd     = issue;
   assign bus.imem_addr   = fetch_pc;
   assign bus.pc          = fetch_pc;
   assign bus.npc         = fetch_pc + ADDR_WIDTH'(1);
   assign bus.instr_valid = (count != '0);
   assign bus.instr       = head.data;
   assign bus.instr_pc    = head.pc;
   assign bus.instr_npc   = head.pc + ADDR_WIDTH'(1);
   assign bus.fifo_count  = count;

   overflow_chk: assert property (@(posedge clock) disable iff (!reset)
      (push && !pop) |-> (count < CW'(DEPTH)));
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit; imem model returns addr ^ 16'hA5A5 one cycle after a read.
module tb_fetch_prefetch_unit;
   logic clock;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   rd_cnt;
   int   n_seen;
   logic [15:0] seen_pc;

   fetch_prefetch_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(4)) bus ();

   fetch_prefetch_unit #(
      .ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(4), .RESET_PC(16'h3000)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (bus.imem_rd) bus.imem_rdata <= bus.imem_addr ^ 16'hA5A5;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a head entry with instr_ready=1, checks it and lets it pop.
   task automatic consume(input logic [15:0] ep);
      int k;
      logic [15:0] en;
      logic [15:0] ei;
      k  = 0;
      en = ep + 16'd1;
      ei = ep ^ 16'hA5A5;
      while (!bus.instr_valid && k < 20) begin
         tick();
         k++;
      end
      chk("consume_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("consume_pc", {16'd0, bus.instr_pc}, {16'd0, ep});
      chk("consume_instr", {16'd0, bus.instr}, {16'd0, ei});
      chk("consume_npc", {16'd0, bus.instr_npc}, {16'd0, en});
      tick();
   endtask

   task automatic hold_reset();
      reset = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 16'h0000;
      tick();
      tick();
   endtask

   initial begin
      reset = 1'b0;
      bus.enable_fetch = 1'b1;
      bus.instr_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 16'h0000;
      bus.imem_rdata = 16'h0000;
      hold_reset();

      // reset state
      chk("rst_imem_rd", {31'd0, bus.imem_rd}, 32'd0);
      chk("rst_pc", {16'd0, bus.pc}, 32'h3000);
      chk("rst_npc", {16'd0, bus.npc}, 32'h3001);
      chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("rst_count", {29'd0, bus.fifo_count}, 32'd0);

      // streaming from reset
      reset = 1'b1;
      #1;
      chk("s1_c0_rd", {31'd0, bus.imem_rd}, 32'd1);
      chk("s1_c0_addr", {16'd0, bus.imem_addr}, 32'h3000);
      tick();
      chk("s1_c1_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("s1_c1_addr", {16'd0, bus.imem_addr}, 32'h3001);
      tick();
      chk("s1_c2_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("s1_c2_instr", {16'd0, bus.instr}, 32'h95A5);
      chk("s1_c2_pc", {16'd0, bus.instr_pc}, 32'h3000);
      chk("s1_c2_npc", {16'd0, bus.instr_npc}, 32'h3001);
      chk("s1_c2_count", {29'd0, bus.fifo_count}, 32'd1);
      tick();
      chk("s1_c3_pc", {16'd0, bus.instr_pc}, 32'h3001);
      chk("s1_c3_instr", {16'd0, bus.instr}, 32'h95A4);
      tick();
      chk("s1_c4_pc", {16'd0, bus.instr_pc}, 32'h3002);

      // stall: ready low from reset, exactly DEPTH reads issued
      bus.instr_ready = 1'b0;
      hold_reset();
      reset = 1'b1;
      rd_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (bus.imem_rd) rd_cnt++;
         tick();
      end
      chk("s2_reads", rd_cnt, 32'd4);
      chk("s2_count", {29'd0, bus.fifo_count}, 32'd4);
      chk("s2_rd_off", {31'd0, bus.imem_rd}, 32'd0);
      chk("s2_head", {16'd0, bus.instr_pc}, 32'h3000);
      bus.instr_ready = 1'b1;
      for (int i = 0; i < 6; i++) consume(16'h3000 + 16'(i));

      // redirect with count=3 and a read in flight
      bus.instr_ready = 1'b0;
      hold_reset();
      reset = 1'b1;
      tick(); tick(); tick(); tick();
      chk("s3_pre_count", {29'd0, bus.fifo_count}, 32'd3);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 16'h4000;
      bus.instr_ready = 1'b1;
      #1;
      chk("s3_redir_rd", {31'd0, bus.imem_rd}, 32'd0);
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      chk("s3_count0", {29'd0, bus.fifo_count}, 32'd0);
      chk("s3_valid0", {31'd0, bus.instr_valid}, 32'd0);
      chk("s3_addr", {16'd0, bus.imem_addr}, 32'h4000);
      chk("s3_rd", {31'd0, bus.imem_rd}, 32'd1);
      tick();
      chk("s3_valid1", {31'd0, bus.instr_valid}, 32'd0);
      tick();
      chk("s3_valid2", {31'd0, bus.instr_valid}, 32'd1);
      for (int i = 0; i < 4; i++) consume(16'h4000 + 16'(i));

      // redirect to FFFF: wrap of pc and instr_npc
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 16'hFFFF;
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      chk("s4_pc", {16'd0, bus.pc}, 32'hFFFF);
      chk("s4_npc", {16'd0, bus.npc}, 32'h0000);
      consume(16'hFFFF);
      consume(16'h0000);

      // back-to-back redirects: last one wins
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 16'h1234;
      tick();
      bus.redirect_pc = 16'h5678;
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      chk("s4_last_pc", {16'd0, bus.pc}, 32'h5678);
      consume(16'h5678);
      consume(16'h5679);

      // enable_fetch dropped with one read in flight
      hold_reset();
      bus.enable_fetch = 1'b1;
      bus.instr_ready = 1'b1;
      reset = 1'b1;
      #1;
      chk("s5_c0_rd", {31'd0, bus.imem_rd}, 32'd1);
      tick();
      bus.enable_fetch = 1'b0;
      #1;
      chk("s5_c1_rd", {31'd0, bus.imem_rd}, 32'd0);
      rd_cnt = 0;
      n_seen = 0;
      seen_pc = 16'h0000;
      for (int i = 0; i < 6; i++) begin
         if (bus.instr_valid) begin
            n_seen++;
            seen_pc = bus.instr_pc;
         end
         if (bus.imem_rd) rd_cnt++;
         tick();
      end
      chk("s5_delivered", n_seen, 32'd1);
      chk("s5_pc", {16'd0, seen_pc}, 32'h3000);
      chk("s5_no_reads", rd_cnt, 32'd0);
      bus.enable_fetch = 1'b1;

      // async reset mid-stream with two entries buffered
      bus.instr_ready = 1'b0;
      hold_reset();
      reset = 1'b1;
      tick(); tick(); tick();
      chk("s6_count2", {29'd0, bus.fifo_count}, 32'd2);
      #2;
      reset = 1'b0;
      #1;
      chk("s6_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("s6_pc", {16'd0, bus.pc}, 32'h3000);
      chk("s6_count", {29'd0, bus.fifo_count}, 32'd0);
      chk("s6_rd", {31'd0, bus.imem_rd}, 32'd0);
      tick();
      tick();
      bus.instr_ready = 1'b1;
      reset = 1'b1;
      consume(16'h3000);
      consume(16'h3001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
